// File: rtl/light_sample_ctrl_if.sv
// Port bundle for the light-sensor sampler: RAT MCU port bus plus the ADC wrapper handshake.
// The master side drives MCU writes and the ADC results; the slave side is the sampler.
interface light_sample_ctrl_if;
    logic [7:0]  port_id;
    logic [7:0]  out_port;
    logic        io_strb;
    logic [7:0]  in_port;
    logic        adc_convst;
    logic        adc_eoc;
    logic [11:0] adc_data;
    logic        intr;
    logic        busy;

    modport master (
        output port_id, out_port, io_strb, adc_eoc, adc_data,
        input  in_port, adc_convst, intr, busy
    );

    modport slave (
        input  port_id, out_port, io_strb, adc_eoc, adc_data,
        output in_port, adc_convst, intr, busy
    );
endinterface

// File: rtl/light_sample_ctrl.sv
// Periodic light-sensor sampler: triggers ADC conversions, averages 2^AVG_LOG2 results,
// applies a hysteresis threshold and pulses intr on each dark/light transition.
module light_sample_ctrl #(
    parameter int         AVG_LOG2   = 2,
    parameter int         PRESCALE_W = 8,
    parameter int         HYST       = 4,
    parameter int         TIMEOUT    = 255,
    parameter logic [7:0] LIGHT_ID   = 8'h96,
    parameter logic [7:0] CTRL_ID    = 8'h97,
    parameter logic [7:0] THRESH_ID  = 8'h98,
    parameter logic [7:0] PERIOD_ID  = 8'h99,
    parameter logic [7:0] STAT_ID    = 8'h9A
) (
    input logic                CLK,
    input logic                RESET,
    light_sample_ctrl_if.slave bus
);

    localparam int ACC_W = 12 + AVG_LOG2;
    localparam int CNT_W = AVG_LOG2 + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(1 << AVG_LOG2);
    localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [1:0]            ctrl_q, ctrl_d;
    logic [7:0]            thresh_q, thresh_d;
    logic [7:0]            period_q, period_d;
    logic [ACC_W-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [7:0]            avg8_q, avg8_d;
    logic                  dark_q, dark_d;
    logic                  err_q, err_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [7:0]            per_cnt_q, per_cnt_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic                  convst_q, convst_d;
    logic                  intr_q, intr_d;

    logic                  tick;
    logic [CNT_W-1:0]      cnt_inc;
    logic [7:0]            avg8_new;
    logic                  dark_next;
    logic                  busy;

    // Upper hysteresis bound, saturated so a threshold near full scale can still be crossed.
    function automatic logic [7:0] sat_upper(input logic [7:0] thr);
        logic [8:0] sum;
        sum = {1'b0, thr} + 9'(HYST);
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    wire wr_ctrl   = bus.io_strb && (bus.port_id == CTRL_ID);
    wire wr_thresh = bus.io_strb && (bus.port_id == THRESH_ID);
    wire wr_period = bus.io_strb && (bus.port_id == PERIOD_ID);

    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign avg8_new  = acc_q[AVG_LOG2+4 +: 8];
    assign dark_next = dark_q ? (avg8_new < sat_upper(thresh_q)) : (avg8_new < thresh_q);
    assign busy      = (state_q != S_IDLE);

    always_comb begin
        state_d   = state_q;
        ctrl_d    = ctrl_q;
        thresh_d  = thresh_q;
        period_d  = period_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        avg8_d    = avg8_q;
        dark_d    = dark_q;
        err_d     = err_q;
        presc_d   = presc_q;
        per_cnt_d = per_cnt_q;
        tmo_d     = tmo_q;
        convst_d  = 1'b0;
        intr_d    = 1'b0;
        tick      = 1'b0;

        if (wr_ctrl) begin
            ctrl_d = bus.out_port[1:0];
            if (bus.out_port[7]) err_d = 1'b0;
        end
        if (wr_thresh) thresh_d = bus.out_port;
        if (wr_period) period_d = bus.out_port;

        // Interval timer: prescaler wrap steps the period counter; tick when it passes zero.
        if (!ctrl_q[0]) begin
            presc_d   = '0;
            per_cnt_d = '0;
        end else begin
            presc_d = presc_q + PRESCALE_W'(1);
            if (&presc_q) begin
                if (per_cnt_q == 8'd0) begin
                    tick      = 1'b1;
                    per_cnt_d = period_q;
                end else begin
                    per_cnt_d = per_cnt_q - 8'd1;
                end
            end
        end

        // The abort decision looks at the enable being written this edge so no stray convst escapes.
        case (state_q)
            S_IDLE: begin
                if (tick && ctrl_d[0]) begin
                    convst_d = 1'b1;
                    tmo_d    = '0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!ctrl_d[0]) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (bus.adc_eoc) begin
                    acc_d = acc_q + ACC_W'(bus.adc_data);
                    cnt_d = cnt_inc;
                    if (cnt_inc == CNT_FULL) begin
                        state_d = S_DONE;
                    end else begin
                        convst_d = 1'b1;
                        tmo_d    = '0;
                    end
                end else if (tmo_q == TMO_MAX) begin
                    err_d   = 1'b1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DONE: begin
                avg8_d  = avg8_new;
                dark_d  = dark_next;
                intr_d  = ctrl_q[1] && (dark_next != dark_q);
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            ctrl_q    <= '0;
            thresh_q  <= '0;
            period_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            avg8_q    <= '0;
            dark_q    <= 1'b0;
            err_q     <= 1'b0;
            presc_q   <= '0;
            per_cnt_q <= '0;
            tmo_q     <= '0;
            convst_q  <= 1'b0;
            intr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            ctrl_q    <= ctrl_d;
            thresh_q  <= thresh_d;
            period_q  <= period_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            avg8_q    <= avg8_d;
            dark_q    <= dark_d;
            err_q     <= err_d;
            presc_q   <= presc_d;
            per_cnt_q <= per_cnt_d;
            tmo_q     <= tmo_d;
            convst_q  <= convst_d;
            intr_q    <= intr_d;
        end
    end

    assign bus.adc_convst = convst_q;
    assign bus.intr       = intr_q;
    assign bus.busy       = busy;

    always_comb begin
        bus.in_port = 8'h00;
        if (bus.port_id == LIGHT_ID)     bus.in_port = avg8_q;
        else if (bus.port_id == STAT_ID) bus.in_port = {err_q, dark_q, busy, 5'b0};
    end

endmodule

// File: tb/tb_light_sample_ctrl.sv
// Randomized bench for light_sample_ctrl: an ADC responder with random latency feeds samples,
// and a burst-level model predicts the average, dark flag, interrupt and error status.
module tb_light_sample_ctrl;

    localparam int         AVG_LOG2  = 2;
    localparam int         NSAMP     = 1 << AVG_LOG2;
    localparam int         HYST      = 4;
    localparam logic [7:0] LIGHT_ID  = 8'h96;
    localparam logic [7:0] CTRL_ID   = 8'h97;
    localparam logic [7:0] THRESH_ID = 8'h98;
    localparam logic [7:0] PERIOD_ID = 8'h99;
    localparam logic [7:0] STAT_ID   = 8'h9A;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    light_sample_ctrl_if bus();

    light_sample_ctrl dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Cycle counter and event monitor, sampled on the falling edge.
    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_convst  = 0;
    int n_intr    = 0;
    int last_eoc  = 0;
    int last_intr = 0;
    int cv_cyc [256];

    always @(negedge CLK) begin
        if (bus.adc_convst === 1'b1) begin
            cv_cyc[n_convst & 255] = cyc;
            n_convst++;
        end
        if (bus.adc_eoc === 1'b1) last_eoc = cyc;
        if (bus.intr === 1'b1) begin
            n_intr++;
            last_intr = cyc;
        end
    end

    // ADC responder: answers each convst with the next queued sample after 1..4 cycles.
    logic [11:0] samp [256];
    int          samp_wr    = 0;
    int          samp_rd    = 0;
    int          adc_cd     = 0;
    logic        adc_on     = 1'b1;
    int          inject_cnt = 0;
    int          inj_done   = 0;

    always begin
        @(posedge CLK);
        #1;
        bus.adc_eoc = 1'b0;
        if (inject_cnt != inj_done) begin
            inj_done++;
            bus.adc_eoc  = 1'b1;
            bus.adc_data = 12'hFFF;
        end else if (adc_cd > 0) begin
            adc_cd--;
            if (adc_cd == 0) begin
                bus.adc_eoc  = 1'b1;
                bus.adc_data = samp[samp_rd & 255];
                samp_rd++;
            end
        end
        if (bus.adc_convst === 1'b1 && adc_on) adc_cd = $urandom_range(1, 4);
    end

    // Reference state kept at the level of "what the MCU should see".
    logic [7:0] m_thresh = 8'h00;
    logic [7:0] m_avg8   = 8'h00;
    logic       m_dark   = 1'b0;
    logic       m_err    = 1'b0;
    logic       m_ie     = 1'b0;

    task automatic wr(input logic [7:0] id, input logic [7:0] data);
        @(posedge CLK);
        #1;
        bus.port_id  = id;
        bus.out_port = data;
        bus.io_strb  = 1'b1;
        @(posedge CLK);
        #1;
        bus.io_strb  = 1'b0;
    endtask

    task automatic rd(input logic [7:0] id, output logic [7:0] d);
        @(negedge CLK);
        bus.port_id = id;
        #1;
        d = bus.in_port;
    endtask

    task automatic set_ctrl(input logic [7:0] v);
        wr(CTRL_ID, v);
        m_ie = v[1];
        if (v[7]) m_err = 1'b0;
    endtask

    task automatic set_thresh(input logic [7:0] v);
        wr(THRESH_ID, v);
        m_thresh = v;
    endtask

    task automatic run_burst(input logic [11:0] s0, input logic [11:0] s1,
                             input logic [11:0] s2, input logic [11:0] s3,
                             output int first_cv);
        int         c0, i0, k, sum, hi;
        logic       new_dark, exp_intr;
        logic [7:0] d;
        c0 = n_convst;
        i0 = n_intr;
        samp[samp_wr & 255] = s0; samp_wr++;
        samp[samp_wr & 255] = s1; samp_wr++;
        samp[samp_wr & 255] = s2; samp_wr++;
        samp[samp_wr & 255] = s3; samp_wr++;
        sum = int'(s0) + int'(s1) + int'(s2) + int'(s3);

        k = 0;
        while (samp_rd != samp_wr && k < 3000) begin
            @(negedge CLK);
            k++;
        end
        chk("burst_consumed", {31'd0, k < 3000}, 32'd1);
        k = 0;
        while (bus.busy !== 1'b0 && k < 100) begin
            @(negedge CLK);
            k++;
        end
        repeat (3) @(negedge CLK);
        first_cv = cv_cyc[c0 & 255];

        m_avg8 = 8'((sum / NSAMP) / 16);
        hi = int'(m_thresh) + HYST;
        if (hi > 255) hi = 255;
        new_dark = m_dark ? !(int'(m_avg8) >= hi) : (m_avg8 < m_thresh);
        exp_intr = m_ie && (new_dark != m_dark);
        m_dark   = new_dark;

        chk("convst_count", n_convst - c0, NSAMP);
        rd(LIGHT_ID, d);
        chk("avg8", {24'd0, d}, {24'd0, m_avg8});
        rd(STAT_ID, d);
        chk("stat_after_burst", {24'd0, d}, {24'd0, m_err, m_dark, 6'b0});
        chk("intr_count", n_intr - i0, {31'd0, exp_intr});
        if (exp_intr) chk("intr_latency", last_intr - last_eoc, 32'd2);
    endtask

    function automatic logic [11:0] rsamp();
        return 12'($urandom_range(0, 4095));
    endfunction

    initial begin
        int         fc1, fc2, c0, c1, k, dcy;
        logic [7:0] d;
        logic [7:0] t;

        RESET        = 1'b1;
        bus.port_id  = 8'h00;
        bus.out_port = 8'h00;
        bus.io_strb  = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_convst", {31'd0, bus.adc_convst}, 32'd0);
        chk("rst_intr",   {31'd0, bus.intr},       32'd0);
        chk("rst_busy",   {31'd0, bus.busy},       32'd0);
        RESET = 1'b0;
        rd(STAT_ID, d);
        chk("rst_stat", {24'd0, d}, 32'h00);
        rd(LIGHT_ID, d);
        chk("rst_light", {24'd0, d}, 32'h00);

        // Averaging with a fixed pattern.
        wr(PERIOD_ID, 8'h00);
        set_ctrl(8'h03);
        run_burst(12'h100, 12'h200, 12'h300, 12'h400, fc1);
        chk("avg_pattern", {24'd0, m_avg8}, 32'h28);

        // Hysteresis: go dark, stay dark inside the band, then go light.
        set_thresh(8'h40);
        run_burst(12'h3F0, 12'h3F0, 12'h3F0, 12'h3F0, fc1);
        run_burst(12'h420, 12'h420, 12'h420, 12'h420, fc1);
        run_burst(12'h440, 12'h440, 12'h440, 12'h440, fc1);

        // Random thresholds and samples, clustered around the threshold half the time.
        for (int i = 0; i < 8; i++) begin
            t = 8'($urandom_range(0, 255));
            set_thresh(t);
            if (i % 2 == 0) begin
                run_burst(rsamp(), rsamp(), rsamp(), rsamp(), fc1);
            end else begin
                logic [11:0] b;
                b = 12'({t, 4'h0} + 12'($urandom_range(0, 95)) - 12'd32);
                run_burst(b, b + 12'd8, b, b + 12'd16, fc1);
            end
        end

        // ie=0: dark still follows the samples but no interrupt.
        set_ctrl(8'h01);
        set_thresh(8'h80);
        run_burst(12'h000, 12'h000, 12'h000, 12'h000, fc1);
        run_burst(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, fc1);
        set_ctrl(8'h03);

        // Timeout: ADC ignores convst, err must set and the FSM must return to idle.
        adc_on = 1'b0;
        c0 = n_convst;
        k = 0;
        while (n_convst == c0 && k < 700) begin
            @(negedge CLK);
            k++;
        end
        chk("tmo_convst_seen", {31'd0, k < 700}, 32'd1);
        k = 0;
        d = 8'h00;
        while (d[7] !== 1'b1 && k < 400) begin
            rd(STAT_ID, d);
            k++;
        end
        dcy = cyc - cv_cyc[c0 & 255];
        m_err = 1'b1;
        chk("tmo_stat", {24'd0, d}, {24'd0, m_err, m_dark, 6'b0});
        chk("tmo_delay_window", {31'd0, (dcy >= 254 && dcy <= 258)}, 32'd1);
        set_ctrl(8'h00);
        adc_on = 1'b1;
        set_ctrl(8'h83);
        rd(STAT_ID, d);
        chk("err_clr", {24'd0, d}, {24'd0, m_err, m_dark, 6'b0});
        run_burst(rsamp(), rsamp(), rsamp(), rsamp(), fc1);

        // Abort in WAIT: no further convst, late eoc ignored.
        adc_on = 1'b0;
        c0 = n_convst;
        k = 0;
        while (n_convst == c0 && k < 700) begin
            @(negedge CLK);
            k++;
        end
        chk("abort_convst_seen", {31'd0, k < 700}, 32'd1);
        repeat (5) @(posedge CLK);
        set_ctrl(8'h00);
        rd(STAT_ID, d);
        chk("abort_stat", {24'd0, d}, {24'd0, m_err, m_dark, 6'b0});
        c1 = n_convst;
        repeat (600) @(negedge CLK);
        chk("abort_no_convst", n_convst - c1, 32'd0);
        inject_cnt++;
        repeat (5) @(negedge CLK);
        rd(LIGHT_ID, d);
        chk("abort_light_kept", {24'd0, d}, {24'd0, m_avg8});
        rd(STAT_ID, d);
        chk("abort_stat_late_eoc", {24'd0, d}, {24'd0, m_err, m_dark, 6'b0});
        adc_on = 1'b1;

        // Period 3: bursts start (3+1)*256 cycles apart.
        wr(PERIOD_ID, 8'h03);
        set_ctrl(8'h03);
        run_burst(rsamp(), rsamp(), rsamp(), rsamp(), fc1);
        run_burst(rsamp(), rsamp(), rsamp(), rsamp(), fc2);
        chk("period_spacing", fc2 - fc1, 32'd1024);
        set_ctrl(8'h00);
        wr(PERIOD_ID, 8'h00);
        set_ctrl(8'h03);

        // Saturated upper bound: thresh FE, average FF must still clear dark.
        set_thresh(8'hFE);
        run_burst(12'h000, 12'h000, 12'h000, 12'h000, fc1);
        chk("sat_dark_set", {31'd0, m_dark}, 32'd1);
        run_burst(12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, fc1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

endmodule
